// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Load funct3 encodings and the FIFO entry layout.
package wb_pkg;

   localparam int unsigned WB_XLEN = 32;
   localparam int unsigned WB_RD_W = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [WB_RD_W-1:0] rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with occupancy count.
// Caller never pushes when full nor pops when empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  wb_entry_t                wdata,
   input  logic                     pop,
   output wb_entry_t                rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates LSU and ALU results onto the register-file write port.
// LSU always wins; ALU results queue in a small FIFO or bypass it when idle.
module wb_stage
   import wb_pkg::*;
#(
   parameter int unsigned N_REGS    = 16,
   parameter int unsigned XLEN      = WB_XLEN,
   parameter int unsigned RD_W      = WB_RD_W,
   parameter int unsigned ALU_DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [RD_W-1:0]              alu_rd,
   input  logic [XLEN-1:0]              alu_data,
   input  logic                         lsu_valid,
   input  logic [RD_W-1:0]              lsu_rd,
   input  logic [XLEN-1:0]              lsu_rdata,
   input  logic [2:0]                   lsu_funct3,
   input  logic [1:0]                   lsu_addr_lo,
   output logic                         rf_wen,
   output logic [RD_W-1:0]              rf_rd,
   output logic [XLEN-1:0]              rf_wdata,
   output logic                         load_err,
   output logic [$clog2(ALU_DEPTH):0]   alu_count
);

   localparam int unsigned CW = $clog2(ALU_DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(ALU_DEPTH);

   // Returns {err, formatted data}.
   function automatic logic [XLEN:0] fmt_load(input logic [XLEN-1:0] word,
                                              input logic [2:0]      f3,
                                              input logic [1:0]      lo);
      logic [XLEN-1:0] lane;
      logic [XLEN-1:0] res;
      logic            err;
      lane = word >> {lo, 3'b000};
      res  = lane;
      err  = 1'b0;
      case (f3)
         F3_LB:   res = {{(XLEN-8){lane[7]}}, lane[7:0]};
         F3_LBU:  res = {{(XLEN-8){1'b0}}, lane[7:0]};
         F3_LH: begin
            res = {{(XLEN-16){lane[15]}}, lane[15:0]};
            err = lo[0];
         end
         F3_LHU: begin
            res = {{(XLEN-16){1'b0}}, lane[15:0]};
            err = lo[0];
         end
         F3_LW:   err = (lo != 2'b00);
         default: err = 1'b1;
      endcase
      return {err, res};
   endfunction

   function automatic logic rd_ok(input logic [RD_W-1:0] rd);
      return (rd != '0) && ({1'b0, rd} < (RD_W+1)'(N_REGS));
   endfunction

   wb_entry_t       head;
   wb_entry_t       push_entry;
   logic            fifo_empty;
   logic            alu_fire;
   logic            push;
   logic            pop;
   logic            bypass;
   logic [XLEN:0]   fmt;
   logic            sel_valid;
   logic            sel_err;
   logic [RD_W-1:0] sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            wen_d;

   // Held low during reset so nothing is accepted into a flushing FIFO.
   assign alu_ready  = reset_n && (alu_count < FULL);
   assign alu_fire   = alu_valid && alu_ready;
   assign fifo_empty = (alu_count == '0);
   assign pop        = !lsu_valid && !fifo_empty;
   assign bypass     = !lsu_valid && fifo_empty && alu_fire;
   assign push       = alu_fire && !bypass;
   assign push_entry = '{rd: alu_rd, data: alu_data};
   assign fmt        = fmt_load(lsu_rdata, lsu_funct3, lsu_addr_lo);

   wb_fifo #(
      .DEPTH (ALU_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (push_entry),
      .pop     (pop),
      .rdata   (head),
      .count   (alu_count)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_err   = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (lsu_valid) begin
         sel_valid = 1'b1;
         sel_err   = fmt[XLEN];
         sel_rd    = lsu_rd;
         sel_data  = fmt[XLEN-1:0];
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel_rd    = head.rd;
         sel_data  = head.data;
      end else if (alu_fire) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end
   end

   assign wen_d = sel_valid && !sel_err && rd_ok(sel_rd);

   // rd/wdata only move on a real write so they hold while wen is low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_wen   <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
         load_err <= 1'b0;
      end else begin
         rf_wen   <= wen_d;
         load_err <= sel_err;
         if (wen_d) begin
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

   logic        clock;
   logic        reset_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_rdata;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_addr_lo;
   logic        rf_wen;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic        load_err;
   logic [1:0]  alu_count;

   int errors = 0;
   int checks = 0;

   wb_stage dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_rd      (lsu_rd),
      .lsu_rdata   (lsu_rdata),
      .lsu_funct3  (lsu_funct3),
      .lsu_addr_lo (lsu_addr_lo),
      .rf_wen      (rf_wen),
      .rf_rd       (rf_rd),
      .rf_wdata    (rf_wdata),
      .load_err    (load_err),
      .alu_count   (alu_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
      lsu_valid   = 1'b0;
      lsu_rd      = '0;
      lsu_rdata   = '0;
      lsu_funct3  = 3'b010;
      lsu_addr_lo = '0;
   endtask

   task automatic test_reset;
      checks++;
      if (rf_wen !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0 || load_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got wen=%b rd=%0d wdata=%h err=%b, want 0 0 0 0",
                  rf_wen, rf_rd, rf_wdata, load_err);
      end
      checks++;
      if (alu_ready !== 1'b0 || alu_count !== 2'd0) begin
         errors++;
         $display("FAIL reset_ready: got ready=%b count=%0d, want 0 0", alu_ready, alu_count);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", alu_ready);
      end
   endtask

   task automatic test_alu_only;
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'h1234;
      tick();
      alu_valid = 1'b0;
      checks++;
      if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h1234 || alu_count !== 2'd0) begin
         errors++;
         $display("FAIL alu_bypass: got wen=%b rd=%0d wdata=%h count=%0d, want 1 5 1234 0",
                  rf_wen, rf_rd, rf_wdata, alu_count);
      end
      tick();
      checks++;
      if (rf_wen !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL alu_hold: got wen=%b rd=%0d wdata=%h, want 0 5 1234",
                  rf_wen, rf_rd, rf_wdata);
      end
   endtask

   task automatic test_collision;
      lsu_valid   = 1'b1;
      lsu_rd      = 5'd3;
      lsu_rdata   = 32'hDEADBEEF;
      lsu_funct3  = 3'b010;
      lsu_addr_lo = 2'd0;
      alu_valid   = 1'b1;
      alu_rd      = 5'd4;
      alu_data    = 32'd7;
      tick();
      idle_inputs();
      checks++;
      if (rf_wen !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'hDEADBEEF || alu_count !== 2'd1) begin
         errors++;
         $display("FAIL collision_lsu: got wen=%b rd=%0d wdata=%h count=%0d, want 1 3 deadbeef 1",
                  rf_wen, rf_rd, rf_wdata, alu_count);
      end
      tick();
      checks++;
      if (rf_wen !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'd7 || alu_count !== 2'd0) begin
         errors++;
         $display("FAIL collision_alu: got wen=%b rd=%0d wdata=%h count=%0d, want 1 4 7 0",
                  rf_wen, rf_rd, rf_wdata, alu_count);
      end
      tick();
      checks++;
      if (rf_wen !== 1'b0) begin
         errors++;
         $display("FAIL collision_idle: got wen=%b want 0", rf_wen);
      end
   endtask

   task automatic test_back_to_back;
      int exp_ready [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
      int exp_rd    [8] = '{8, 9, 10, 11, 1, 2, 3, 4};
      int exp_cnt   [8] = '{1, 2, 2, 2, 1, 1, 1, 0};
      int next_alu;
      logic [31:0] exp_data;
      next_alu = 1;
      for (int c = 0; c < 8; c++) begin
         lsu_valid   = (c < 4);
         lsu_rd      = 5'(8 + c);
         lsu_rdata   = 32'h100 + 32'(c);
         lsu_funct3  = 3'b010;
         lsu_addr_lo = 2'd0;
         alu_valid   = (next_alu <= 4);
         alu_rd      = 5'(next_alu);
         alu_data    = 32'hA0 + 32'(next_alu);
         #1;
         checks++;
         if (alu_ready !== exp_ready[c][0]) begin
            errors++;
            $display("FAIL bp_ready c=%0d: got %b want %0d", c, alu_ready, exp_ready[c]);
         end
         if (exp_ready[c] == 1 && next_alu <= 4) next_alu++;
         tick();
         exp_data = (c < 4) ? 32'h100 + 32'(c) : 32'hA0 + 32'(exp_rd[c]);
         checks++;
         if (rf_wen !== 1'b1 || rf_rd !== 5'(exp_rd[c]) || rf_wdata !== exp_data
             || alu_count !== 2'(exp_cnt[c])) begin
            errors++;
            $display("FAIL bp_write c=%0d: got wen=%b rd=%0d wdata=%h count=%0d, want 1 %0d %h %0d",
                     c, rf_wen, rf_rd, rf_wdata, alu_count, exp_rd[c], exp_data, exp_cnt[c]);
         end
      end
      idle_inputs();
      tick();
      checks++;
      if (rf_wen !== 1'b0 || alu_count !== 2'd0) begin
         errors++;
         $display("FAIL bp_drained: got wen=%b count=%0d, want 0 0", rf_wen, alu_count);
      end
   endtask

   task automatic test_load_format;
      logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b011};
      logic [1:0]  lo  [6] = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
      logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 0, 0, 0};
      logic        bad [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] last;
      last = 32'hFFFF80FF;
      for (int i = 0; i < 6; i++) begin
         lsu_valid   = 1'b1;
         lsu_rd      = 5'd6;
         lsu_rdata   = 32'h80FF7F01;
         lsu_funct3  = f3[i];
         lsu_addr_lo = lo[i];
         tick();
         lsu_valid = 1'b0;
         checks++;
         if (bad[i]) begin
            if (rf_wen !== 1'b0 || load_err !== 1'b1 || rf_wdata !== last) begin
               errors++;
               $display("FAIL load_err i=%0d: got wen=%b err=%b wdata=%h, want 0 1 %h",
                        i, rf_wen, load_err, rf_wdata, last);
            end
         end else if (rf_wen !== 1'b1 || load_err !== 1'b0 || rf_wdata !== exp[i]) begin
            errors++;
            $display("FAIL load_fmt i=%0d: got wen=%b err=%b wdata=%h, want 1 0 %h",
                     i, rf_wen, load_err, rf_wdata, exp[i]);
         end
         tick();
         checks++;
         if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_err_pulse i=%0d: got %b want 0", i, load_err);
         end
      end
   endtask

   task automatic test_filter;
      logic [4:0] rds [3] = '{5'd0, 5'd20, 5'd15};
      logic       wen [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1;
         alu_rd    = rds[i];
         alu_data  = 32'h55 + 32'(i);
         #1;
         checks++;
         if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL filter_ready rd=%0d: got %b want 1", rds[i], alu_ready);
         end
         tick();
         alu_valid = 1'b0;
         checks++;
         if (rf_wen !== wen[i] || alu_count !== 2'd0) begin
            errors++;
            $display("FAIL filter rd=%0d: got wen=%b count=%0d, want %b 0",
                     rds[i], rf_wen, alu_count, wen[i]);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid;
      lsu_valid  = 1'b1;
      lsu_rd     = 5'd9;
      lsu_rdata  = 32'h99;
      lsu_funct3 = 3'b010;
      alu_valid  = 1'b1;
      alu_rd     = 5'd1;
      alu_data   = 32'h11;
      tick();
      alu_rd   = 5'd2;
      alu_data = 32'h22;
      tick();
      checks++;
      if (alu_count !== 2'd2) begin
         errors++;
         $display("FAIL rst_mid_fill: got count=%0d want 2", alu_count);
      end
      idle_inputs();
      reset_n = 1'b0;
      #1;
      checks++;
      if (alu_count !== 2'd0 || alu_ready !== 1'b0 || rf_wen !== 1'b0 || rf_rd !== 5'd0
          || rf_wdata !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_async: got count=%0d ready=%b wen=%b rd=%0d wdata=%h, want 0 0 0 0 0",
                  alu_count, alu_ready, rf_wen, rf_rd, rf_wdata);
      end
      tick();
      reset_n = 1'b1;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready: got %b want 1", alu_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rf_wen !== 1'b0 || alu_count !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_stale i=%0d: got wen=%b count=%0d, want 0 0",
                     i, rf_wen, alu_count);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      test_reset();
      tick();
      test_alu_only();
      test_collision();
      test_back_to_back();
      test_load_format();
      test_filter();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
